fetch_branch_unit: RTL

//  Consumer end of the program-counter interface. Registers each instruction read from sync imem at programCounter.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/branch_lut.sv | 23 ++
 rtl/fetch_branch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// cpu_pkg -- opcodes, fetch FSM states and absolute-jump table contents for the fetch/branch path.
// Rev 1.0
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_BRR = 3'b001,
    OP_JMP = 3'b111
  } op_t;

  localparam logic [8:0] HALT_WORD = 9'h000;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    RUN,
    FLUSH,
    HALT
  } fbu_state_t;

  // Absolute-jump table contents: entry i holds (i << 4) ^ 16.
  function automatic int unsigned lut_entry(input int unsigned idx);
    return (idx << 4) ^ 32'd16;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_lut.sv
`default_nettype none
// branch_lut -- combinational 2^AW x DW absolute-jump target table filled from cpu_pkg::lut_entry.
// Rev 1.0
module branch_lut
  import cpu_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 10
) (
  input  logic [AW-1:0] index,
  output logic [DW-1:0] target
);

  logic [DW-1:0] entries [2**AW];

  for (genvar i = 0; i < 2**AW; i++) begin : g_entry
    assign entries[i] = DW'(lut_entry(i));
  end

  assign target = entries[index];

endmodule
`default_nettype wire

// File: rtl/fetch_branch_unit.sv
`default_nettype none
// fetch_branch_unit -- instruction register, decode handshake and PC redirect (jump/branch/stall hold).
// Rev 1.0. Define BRANCH_STATS_EN to build the saturating taken/stall counters.
module fetch_branch_unit
  import cpu_pkg::*;
#(
  parameter int D      = 10,
  parameter int IW     = 9,
  parameter int LUT_AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  programCounter,
  input  logic [IW-1:0] imem_data,
  input  logic          cond_flag,
  input  logic          ir_ready,
  output logic [IW-1:0] ir_out,
  output logic [D-1:0]  ir_pc,
  output logic          ir_valid,
  output logic          jumpEn,
  output logic [D-1:0]  target,
  output logic [2:0]    instruction,
  output logic          done,
  output logic [15:0]   taken_cnt,
  output logic [15:0]   stall_cnt
);

  fbu_state_t   state, next_state;
  logic         load, taken, stall;
  logic [2:0]   opcode;
  logic [D-1:0] lut_target, rel_target;

  assign opcode = ir_out[IW-1:IW-3];
  // PC already points past ir_pc, so the offset is pre-decremented by one.
  assign rel_target = {{(D-6){ir_out[5]}}, ir_out[5:0]} - D'(1);

  branch_lut #(
    .AW(LUT_AW),
    .DW(D)
  ) u_lut (
    .index (ir_out[LUT_AW-1:0]),
    .target(lut_target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    load        = 1'b0;
    taken       = 1'b0;
    stall       = 1'b0;
    ir_valid    = 1'b0;
    jumpEn      = 1'b0;
    target      = '0;
    instruction = 3'b000;
    done        = 1'b0;
    case (state)
      IDLE:  next_state = PRIME;
      PRIME: begin
        load       = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        ir_valid = 1'b1;
        if (!ir_ready) begin
          stall       = 1'b1;
          jumpEn      = 1'b1;
          instruction = 3'b001;
        end else begin
          load = 1'b1;
          if (ir_out == IW'(HALT_WORD)) begin
            next_state = HALT;
          end else if (opcode == OP_JMP) begin
            taken       = 1'b1;
            jumpEn      = 1'b1;
            instruction = 3'b111;
            target      = lut_target;
            next_state  = FLUSH;
          end else if (opcode == OP_BRR && cond_flag) begin
            taken       = 1'b1;
            jumpEn      = 1'b1;
            instruction = 3'b001;
            target      = rel_target;
            next_state  = FLUSH;
          end
        end
      end
      FLUSH: begin
        load       = 1'b1;
        next_state = RUN;
      end
      HALT: begin
        done        = 1'b1;
        jumpEn      = 1'b1;
        instruction = 3'b001;
      end
      default: next_state = IDLE;
    endcase
    if (start) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir_out <= '0;
      ir_pc  <= '0;
    end else if (load) begin
      ir_out <= imem_data;
      ir_pc  <= programCounter - D'(1);
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_count, stall_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      taken_count <= '0;
      stall_count <= '0;
    end else if (start) begin
      taken_count <= '0;
      stall_count <= '0;
    end else begin
      if (taken && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
      if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
    end
  end

  assign taken_cnt = taken_count;
  assign stall_cnt = stall_count;
`else
  logic unused_stats;
  assign unused_stats = taken | stall;
  assign taken_cnt    = '0;
  assign stall_cnt    = '0;
`endif

endmodule
`default_nettype wire
